// File: rtl/vga_bus_source_if.sv
// ---------------------------------------------------------------------------
// vga_bus_source_if
//
// Project VGA bus carrier between the timing source and the drawing stages.
//
// Bus layout (MSB first), built with `VGA_BUS_MERGE:
//   hcount[10:0] | vcount[10:0] | hsync | vsync | hblnk | vblnk | rgb[11:0]
//
// Signals:
//   vga_out     `VGA_BUS_SIZE-bit packed timing/colour word
//   frame_tick  one-cycle pulse coincident with hcount=0, vcount=0
//
// Modports:
//   master  driven by the timing source (vga_bus_source)
//   slave   consumed by downstream overlay stages
// ---------------------------------------------------------------------------
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

`ifndef VGA_BUS_MERGE
`define VGA_BUS_MERGE(hc, vc, hs, vs, hb, vb, rgb) {(hc), (vc), (hs), (vs), (hb), (vb), (rgb)}
`endif

interface vga_bus_source_if;
  logic [`VGA_BUS_SIZE-1:0] vga_out;
  logic                     frame_tick;

  modport master (output vga_out, output frame_tick);
  modport slave  (input  vga_out, input  frame_tick);
endinterface

// File: rtl/vga_bus_source.sv
// ---------------------------------------------------------------------------
// vga_bus_source
//
// Head of the display pipeline: free-running VGA timing generator. Produces
// horizontal/vertical counters, positive-polarity sync pulses, blanking
// flags and the active-video colour, packed onto the project VGA bus.
// Default timing is SVGA 800x600 @ 60 Hz (40 MHz pixel clock).
//
// Ports:
//   pclk  in   pixel clock, all logic on its rising edge
//   rst   in   synchronous, active-high reset
//   bus   master modport of vga_bus_source_if (vga_out, frame_tick)
//
// Build option:
//   VGA_SRC_TEST_PATTERN_EN  when defined, active video shows eight
//                            100-pixel colour bars instead of BG_COLOR.
//
// Line and frame totals must not exceed 2048 (11-bit counters).
// ---------------------------------------------------------------------------
module vga_bus_source #(
  parameter int          H_ACTIVE = 800,
  parameter int          H_FP     = 40,
  parameter int          H_SYNC   = 128,
  parameter int          H_BP     = 88,
  parameter int          V_ACTIVE = 600,
  parameter int          V_FP     = 1,
  parameter int          V_SYNC   = 4,
  parameter int          V_BP     = 23,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic               pclk,
  input  logic               rst,
  vga_bus_source_if.master   bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] HB_START = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] VB_START = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_SRC_TEST_PATTERN_EN
  // Pixel (0,0) sits in the white bar.
  localparam logic [11:0] RESET_RGB = 12'hfff;
`else
  localparam logic [11:0] RESET_RGB = BG_COLOR;
`endif

  logic [10:0] r_hcount, r_vcount;
  logic        r_hsync, r_vsync, r_hblnk, r_vblnk, r_frame_tick;
  logic [11:0] r_rgb;

  logic        w_h_wrap;
  logic [10:0] w_hcount_nxt, w_vcount_nxt;
  logic        w_hsync_nxt, w_vsync_nxt, w_hblnk_nxt, w_vblnk_nxt;
  logic        w_frame_tick_nxt;
  logic [11:0] w_active_rgb, w_rgb_nxt;

  // All flags are decoded from the next count, so every field registered on
  // an edge describes the same pixel and the bus carries no skew.
  always_comb begin
    w_h_wrap     = (r_hcount == H_LAST);
    w_hcount_nxt = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
    w_vcount_nxt = r_vcount;
    if (w_h_wrap)
      w_vcount_nxt = (r_vcount == V_LAST) ? 11'd0 : r_vcount + 11'd1;

    w_hblnk_nxt      = (w_hcount_nxt >= HB_START);
    w_hsync_nxt      = (w_hcount_nxt >= HS_START) && (w_hcount_nxt <= HS_END);
    w_vblnk_nxt      = (w_vcount_nxt >= VB_START);
    w_vsync_nxt      = (w_vcount_nxt >= VS_START) && (w_vcount_nxt <= VS_END);
    w_frame_tick_nxt = (w_hcount_nxt == 11'd0) && (w_vcount_nxt == 11'd0);
  end

`ifdef VGA_SRC_TEST_PATTERN_EN
  // Bar select by compare chain on the horizontal position (no divider).
  always_comb begin
    // NOTE: a default assignment first guarantees every path drives the
    // output, so no latch is inferred from an incomplete if/else chain.
    w_active_rgb = 12'h000;
    if      (w_hcount_nxt < 11'd100) w_active_rgb = 12'hfff;
    else if (w_hcount_nxt < 11'd200) w_active_rgb = 12'hff0;
    else if (w_hcount_nxt < 11'd300) w_active_rgb = 12'h0ff;
    else if (w_hcount_nxt < 11'd400) w_active_rgb = 12'h0f0;
    else if (w_hcount_nxt < 11'd500) w_active_rgb = 12'hf0f;
    else if (w_hcount_nxt < 11'd600) w_active_rgb = 12'hf00;
    else if (w_hcount_nxt < 11'd700) w_active_rgb = 12'h00f;
  end
`else
  assign w_active_rgb = BG_COLOR;
`endif

  // Blanking always forces black, in both builds.
  assign w_rgb_nxt = (w_hblnk_nxt || w_vblnk_nxt) ? 12'h000 : w_active_rgb;

  always_ff @(posedge pclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would make results depend on statement order.
    if (rst) begin
      r_hcount     <= 11'd0;
      r_vcount     <= 11'd0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_hblnk      <= 1'b0;
      r_vblnk      <= 1'b0;
      r_frame_tick <= 1'b0;
      r_rgb        <= RESET_RGB;
    end else begin
      r_hcount     <= w_hcount_nxt;
      r_vcount     <= w_vcount_nxt;
      r_hsync      <= w_hsync_nxt;
      r_vsync      <= w_vsync_nxt;
      r_hblnk      <= w_hblnk_nxt;
      r_vblnk      <= w_vblnk_nxt;
      r_frame_tick <= w_frame_tick_nxt;
      r_rgb        <= w_rgb_nxt;
    end
  end

  assign bus.vga_out    = `VGA_BUS_MERGE(r_hcount, r_vcount, r_hsync, r_vsync,
                                         r_hblnk, r_vblnk, r_rgb);
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_bus_source.sv
// ---------------------------------------------------------------------------
// tb_vga_bus_source
//
// Directed bench for vga_bus_source. Horizontal timing is the default SVGA
// line (1056 pixels); the vertical timing is shortened to 12 active lines,
// 1 front porch, 4 sync, 3 back porch (20 lines, 21120 pixels per frame) so
// that two whole frames fit in a short run. Expected vertical windows:
// vblnk lines 12..19, vsync lines 13..16. BG_COLOR is 12'h123.
// ---------------------------------------------------------------------------
module tb_vga_bus_source;

  localparam int H_TOTAL = 1056;
  localparam int V_TOTAL = 20;
  localparam int FRAME   = 21120;
  localparam int HB_LO   = 800;
  localparam int HS_LO   = 840;
  localparam int HS_HI   = 967;
  localparam int VB_LO   = 12;
  localparam int VS_LO   = 13;
  localparam int VS_HI   = 16;
  localparam logic [11:0] BG = 12'h123;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  vga_bus_source_if bus ();

  vga_bus_source #(
    .H_ACTIVE (800), .H_FP (40), .H_SYNC (128), .H_BP (88),
    .V_ACTIVE (12),  .V_FP (1),  .V_SYNC (4),   .V_BP (3),
    .BG_COLOR (BG)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  logic [10:0] hc, vc;
  logic        hs, vs, hb, vb;
  logic [11:0] rgb;
  assign {hc, vc, hs, vs, hb, vb, rgb} = bus.vga_out;

  int n_vec = 0;
  int n_bad = 0;

  // Colour of an active-video pixel at horizontal position h.
  function automatic logic [11:0] exp_active(input int h);
`ifdef VGA_SRC_TEST_PATTERN_EN
    if (h < 100) return 12'hfff;
    if (h < 200) return 12'hff0;
    if (h < 300) return 12'h0ff;
    if (h < 400) return 12'h0f0;
    if (h < 500) return 12'hf0f;
    if (h < 600) return 12'hf00;
    if (h < 700) return 12'h00f;
    return 12'h000;
`else
    return BG;
`endif
  endfunction

  // Advance on falling edges until the bus shows (h, v); an expired budget
  // counts as a failed comparison.
  task automatic wait_until(input int h, input int v, input int budget);
    int n = 0;
    while (!(int'(hc) == h && int'(vc) == v) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    if (!(int'(hc) == h && int'(vc) == v)) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_until: got (%0d,%0d) want (%0d,%0d)", hc, vc, h, v);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    repeat (2000) @(negedge pclk);
    // 2000 pixels after release: hcount 944 on line 1, inside hsync.
    n_vec++;
    if ({hc, vc, hs, hb} !== {11'd944, 11'd1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset: got h=%0d v=%0d hs=%b hb=%b want h=944 v=1 hs=1 hb=1",
               hc, vc, hs, hb);
    end
    rst = 1'b1;
    repeat (5) @(negedge pclk);
    n_vec++;
    if ({hc, vc, hs, vs, hb, vb, bus.frame_tick, rgb} !==
        {11'd0, 11'd0, 5'b00000, exp_active(0)}) begin
      n_bad++;
      $display("FAIL reset_state: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ft=%b rgb=%h",
               hc, vc, hs, vs, hb, vb, bus.frame_tick, rgb);
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge pclk);
      n_vec++;
      if (int'(hc) != i || vc !== 11'd0 || bus.frame_tick !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_count: got h=%0d v=%0d ft=%b want h=%0d v=0 ft=0",
                 hc, vc, bus.frame_tick, i);
      end
    end
  endtask

  task automatic test_bg_color(input int h, input int v);
    wait_until(h, v, 2 * FRAME);
    n_vec++;
    if (rgb !== exp_active(h) || hb !== 1'b0 || vb !== 1'b0) begin
      n_bad++;
      $display("FAIL bg_color(%0d,%0d): got rgb=%h hb=%b vb=%b want rgb=%h hb=0 vb=0",
               h, v, rgb, hb, vb, exp_active(h));
    end
  endtask

  task automatic test_line_wrap;
    wait_until(1055, 10, 2 * FRAME);
    @(negedge pclk);
    n_vec++;
    if (hc !== 11'd0 || vc !== 11'd11 || hb !== 1'b0 || bus.frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL line_wrap: got h=%0d v=%0d hb=%b ft=%b want h=0 v=11 hb=0 ft=0",
               hc, vc, hb, bus.frame_tick);
    end
  endtask

  task automatic test_hsync_window;
    int n_hs = 0;
    int n_hb = 0;
    wait_until(0, 12, 2 * H_TOTAL);
    for (int i = 0; i < H_TOTAL; i++) begin
      logic e_hs, e_hb;
      e_hs = (i >= HS_LO && i <= HS_HI);
      e_hb = (i >= HB_LO);
      n_vec++;
      if (int'(hc) != i || hs !== e_hs || hb !== e_hb) begin
        n_bad++;
        $display("FAIL hsync_window: got h=%0d hs=%b hb=%b want h=%0d hs=%b hb=%b",
                 hc, hs, hb, i, e_hs, e_hb);
      end
      if (hs === 1'b1) n_hs++;
      if (hb === 1'b1) n_hb++;
      @(negedge pclk);
    end
    n_vec++;
    if (n_hs != 128 || n_hb != 256) begin
      n_bad++;
      $display("FAIL hsync_width: got hs=%0d hb=%0d cycles want hs=128 hb=256",
               n_hs, n_hb);
    end
  endtask

`ifdef VGA_SRC_TEST_PATTERN_EN
  task automatic test_pattern;
    int          hpos [5] = '{0, 100, 299, 799, 800};
    logic [11:0] want [5] = '{12'hfff, 12'hff0, 12'h0ff, 12'h000, 12'h000};
    for (int i = 0; i < 5; i++) begin
      wait_until(hpos[i], 5, 2 * FRAME);
      n_vec++;
      if (rgb !== want[i]) begin
        n_bad++;
        $display("FAIL pattern h=%0d: got rgb=%h want %h", hpos[i], rgb, want[i]);
      end
    end
  endtask
`endif

  // Two whole frames from reset against an independent pixel-position model.
  task automatic test_frames;
    int mh = 0;
    int mv = 0;
    int n_ticks = 0;
    int first_tick = -1;
    int last_tick = -1;
    int n_prints = 0;
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    for (int i = 1; i <= 2 * FRAME + 5; i++) begin
      logic        e_hs, e_vs, e_hb, e_vb, e_ft;
      logic [11:0] e_rgb;
      @(negedge pclk);
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv++;
        if (mv == V_TOTAL) mv = 0;
      end
      e_hb  = (mh >= HB_LO);
      e_hs  = (mh >= HS_LO && mh <= HS_HI);
      e_vb  = (mv >= VB_LO);
      e_vs  = (mv >= VS_LO && mv <= VS_HI);
      e_ft  = (mh == 0 && mv == 0);
      e_rgb = (e_hb || e_vb) ? 12'h000 : exp_active(mh);
      n_vec++;
      if (int'(hc) != mh || int'(vc) != mv || hs !== e_hs || vs !== e_vs ||
          hb !== e_hb || vb !== e_vb || bus.frame_tick !== e_ft || rgb !== e_rgb) begin
        n_bad++;
        if (n_prints < 20)
          $display("FAIL frame_cycle %0d: got h=%0d v=%0d hs%b vs%b hb%b vb%b ft%b rgb=%h want h=%0d v=%0d hs%b vs%b hb%b vb%b ft%b rgb=%h",
                   i, hc, vc, hs, vs, hb, vb, bus.frame_tick, rgb,
                   mh, mv, e_hs, e_vs, e_hb, e_vb, e_ft, e_rgb);
        n_prints++;
      end
      if (bus.frame_tick === 1'b1) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
        last_tick = i;
      end
    end
    n_vec++;
    if (n_ticks != 2 || first_tick != FRAME || last_tick - first_tick != FRAME) begin
      n_bad++;
      $display("FAIL frame_tick: got %0d ticks at %0d and %0d want 2 ticks at %0d and %0d",
               n_ticks, first_tick, last_tick, FRAME, 2 * FRAME);
    end
  endtask

  initial begin
    test_reset;
    test_bg_color(400, 6);
    test_line_wrap;
    test_bg_color(799, 11);
    test_hsync_window;
`ifdef VGA_SRC_TEST_PATTERN_EN
    test_pattern;
`endif
    test_frames;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_bus_source.md
# vga_bus_source

- Generates the VGA timing bus, the head of the display pipeline.
- Produces free-running horizontal and vertical counters, sync pulses, blanking flags and a background colour, all packed onto the project VGA bus.
- Every downstream drawing stage (rectangle, sprite and text overlays) consumes this bus and forwards it unchanged in structure.
- Default timing is SVGA 800x600 @ 60 Hz with a 40 MHz pixel clock.

## Interface

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels); line total = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines); frame total = 628
- BG_COLOR, 12'h0_0_0, rgb driven during active video when the test pattern is compiled out

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- vga_out  out  `VGA_BUS_SIZE`  packed bus carrying hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk and rgb[11:0]; packed with the project VGA bus merge macro
- frame_tick  out  1  one-cycle pulse while hcount=0 and vcount=0

## Operation

- Every bus field and frame_tick is a flop.
- The block computes next-state values and registers them together, so all fields are mutually consistent on every cycle.
- There is no skew between count and flags.
- hcount counts 0..H_TOTAL-1 (1055), then wraps to 0.
- vcount increments only on the hcount wrap. It counts 0..V_TOTAL-1 (627), then wraps to 0 on the same edge that wraps hcount.
- hblnk = 1 for hcount in [H_ACTIVE, H_TOTAL-1] = [800, 1055].
- hsync = 1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [840, 967]. Polarity is positive.
- vblnk = 1 for vcount in [600, 627].
- vsync = 1 for vcount in [601, 604], across entire lines. Polarity is positive.
- rgb = 12'h000 whenever hblnk or vblnk is 1. Otherwise rgb is the background value (see Configuration).
- Count widths are 11 bits. Parameters must keep H_TOTAL and V_TOTAL ≤ 2048; larger values are unsupported.

## Timing

- Reset values: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_tick=0.
- rgb resets to the pixel-(0,0) value: BG_COLOR, or white with the pattern enabled.
- First rising edge with rst low:
  - hcount becomes 1.
  - frame_tick is 0, because it asserts only on the wrap into (0,0) and not out of reset.
- Line period: 1056 pclk. Frame period: 663 168 pclk.
- frame_tick is high for exactly one cycle per frame. That cycle is the cycle in which the bus shows hcount=0, vcount=0.
- Latency from the internal count to the bus: 0 cycles. Fields are registered as one word.
- Reset asserted mid-frame: on the next edge all outputs return to reset values. No partial line or partial pulse survives.
- Simultaneous wrap (hcount 1055 and vcount 627): one edge yields hcount=0, vcount=0, all flags 0 and frame_tick=1.
- rst held high: the bus holds the reset values indefinitely.

## Configuration

- Macro: VGA_SRC_TEST_PATTERN_EN.
- Defined: active-video rgb is a colour-bar pattern of eight 100-pixel-wide vertical bars selected by hcount/100.
  - Bar order is white 12'hfff, yellow 12'hff0, cyan 12'h0ff, green 12'h0f0, magenta 12'hf0f, red 12'hf00, blue 12'h00f, black 12'h000.
  - BG_COLOR is ignored.
  - Bar selection is a compare chain on hcount; no divider.
- Undefined: active-video rgb = BG_COLOR. No pattern logic is synthesised.
- Blanking forces rgb=0 in both builds.

## Test plan

- Reset: hold rst for 5 cycles with a mid-frame prior state → every field at its reset value; after release, hcount reads 1, 2, 3 on successive edges.
- Line wrap: run to hcount=1055, vcount=10 → next cycle shows hcount=0, vcount=11, hblnk=0, with no frame_tick.
- hsync window: sample one full line → hsync=1 exactly for hcount 840..967 (128 cycles) and hblnk=1 exactly for 800..1055.
- Frame wrap and vertical flags: run 2 full frames →
  - vsync high for lines 601..604.
  - vblnk high for lines 600..627.
  - frame_tick pulses once per frame, exactly 663 168 cycles apart, coincident with hcount=0, vcount=0.
- Blanking colour: check every cycle with hblnk or vblnk set → rgb=12'h000. With the macro undefined and BG_COLOR=12'h123 → rgb=12'h123 at (0,0), (799,599) and (400,300).
- Pattern (macro defined) at vcount=50:
  - rgb=12'hfff at hcount 0.
  - rgb=12'hff0 at hcount 100.
  - rgb=12'h0ff at hcount 299 → 12'h0ff is the cyan bar, bar index 2.
  - rgb=12'h000 at hcount 799.
  - rgb=12'h000 at hcount 800.
